datapath: RTL and testbench

//  Multicycle MIPS datapath. Sits between the external control FSM and the unified instruction/data memory.

---
 rtl/datapath.sv | 123 ++++++++++++
 tb/tb_datapath.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, 32x32 register file, A/B, ALU, ALUOut; memory is external.
// Outputs are combinational from state and controls; state updates on each rising edge, no backpressure.
module datapath (
  input  logic        clk,
  input  logic        reset_,
  input  logic        IorD,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSrc,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        MemWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        Branch,
  input  logic [1:0]  ALUOp,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] RD,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic [31:0] Adr,
  output logic [31:0] WD,
  output logic        WE,
  output logic        overflow
);

  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
  logic [31:0] r_rf [32];

  logic [31:0] w_sign_imm, w_src_a, w_src_b, w_sum, w_diff;
  logic [31:0] w_alu_result, w_pc_next, w_rd1, w_rd2, w_wd3;
  logic [4:0]  w_wa;
  logic        w_zero, w_pc_en;
  logic        w_unused;

  // ALU decoding happens in the controller; ALUOp is accepted only for port compatibility.
  assign w_unused   = ^ALUOp;

  assign w_sign_imm = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rd1      = r_rf[r_ir[25:21]];
  assign w_rd2      = r_rf[r_ir[20:16]];
  assign w_wa       = RegDst ? r_ir[15:11] : r_ir[20:16];
  assign w_wd3      = MemtoReg ? r_mdr : r_aluout;

  assign w_src_a    = ALUSrcA ? r_a : r_pc;

  always_comb begin
    w_src_b = r_b;
    case (ALUSrcB)
      2'b00: w_src_b = r_b;
      2'b01: w_src_b = 32'd4;
      2'b10: w_src_b = w_sign_imm;
      2'b11: w_src_b = {w_sign_imm[29:0], 2'b00};
      default: w_src_b = r_b;
    endcase
  end

  assign w_sum  = w_src_a + w_src_b;
  assign w_diff = w_src_a - w_src_b;

  always_comb begin
    w_alu_result = 32'd0;
    overflow     = 1'b0;
    case (ALUControl)
      3'b010: begin
        w_alu_result = w_sum;
        overflow     = (w_src_a[31] == w_src_b[31]) && (w_sum[31] != w_src_a[31]);
      end
      3'b110: begin
        w_alu_result = w_diff;
        overflow     = (w_src_a[31] != w_src_b[31]) && (w_diff[31] != w_src_a[31]);
      end
      3'b000: w_alu_result = w_src_a & w_src_b;
      3'b001: w_alu_result = w_src_a | w_src_b;
      3'b111: w_alu_result = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
      3'b100: w_alu_result = w_src_a & ~w_src_b;
      3'b101: w_alu_result = w_src_a | ~w_src_b;
      default: w_alu_result = 32'd0;
    endcase
  end

  assign w_zero = (w_alu_result == 32'd0);

  always_comb begin
    w_pc_next = w_alu_result;
    case (PCSrc)
      2'b01: w_pc_next = r_aluout;
      2'b10: w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      default: w_pc_next = w_alu_result;
    endcase
  end

  assign w_pc_en = PCWrite | (Branch & w_zero);

  // Register 0 is never written and cleared by reset, so it always reads zero.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      r_mdr    <= RD;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alu_result;
      if (IRWrite) r_ir <= RD;
      if (w_pc_en) r_pc <= w_pc_next;
      if (RegWrite && (w_wa != 5'd0)) r_rf[w_wa] <= w_wd3;
    end
  end

  assign OP    = r_ir[31:26];
  assign Funct = r_ir[5:0];
  assign Adr   = IorD ? r_aluout : r_pc;
  assign WD    = r_b;
  assign WE    = MemWrite;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for the multicycle MIPS datapath, driven as a hand-sequenced controller.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset_;
  logic        IorD, ALUSrcA, IRWrite, PCWrite, MemWrite, RegDst, MemtoReg, RegWrite, Branch;
  logic [1:0]  ALUSrcB, PCSrc, ALUOp;
  logic [2:0]  ALUControl;
  logic [31:0] RD;
  logic [5:0]  OP, Funct;
  logic [31:0] Adr, WD;
  logic        WE, overflow;

  logic [31:0] exp_q [$];
  logic [31:0] want;
  int          n_checks = 0;
  int          n_fails  = 0;

  localparam logic [2:0]  ALU_CTL [8] = '{3'b111, 3'b010, 3'b110, 3'b000,
                                          3'b001, 3'b100, 3'b101, 3'b011};
  localparam logic [31:0] ALU_RES [8] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'h00000001,
                                          32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};

  datapath dut (
    .clk(clk), .reset_(reset_), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
    .ALUOp(ALUOp), .ALUControl(ALUControl), .RD(RD), .OP(OP), .Funct(Funct),
    .Adr(Adr), .WD(WD), .WE(WE), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IorD = 0; ALUSrcA = 0; ALUSrcB = 2'b00; PCSrc = 2'b00; IRWrite = 0; PCWrite = 0;
    MemWrite = 0; RegDst = 0; MemtoReg = 0; RegWrite = 0; Branch = 0; ALUOp = 2'b00;
    ALUControl = 3'b000;
  endtask

  // Instruction fetch: IR <= RD, PC <= PC + 4.
  task automatic fetch(input logic [31:0] instr);
    idle();
    RD = instr; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; ALUControl = 3'b010;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset_ = 0; RD = 32'h20080005; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; ALUControl = 3'b010;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    tick(); tick();
    idle();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL reset_adr: got %h want %h", Adr, want); end
    want = exp_q.pop_front(); n_checks++;
    if ({26'd0, OP} !== want) begin n_fails++; $display("FAIL reset_op: got %h want %h", OP, want); end
    want = exp_q.pop_front(); n_checks++;
    if ({26'd0, Funct} !== want) begin n_fails++; $display("FAIL reset_funct: got %h want %h", Funct, want); end
    want = exp_q.pop_front(); n_checks++;
    if (WD !== want) begin n_fails++; $display("FAIL reset_wd: got %h want %h", WD, want); end
    MemWrite = 1;
    exp_q.push_back(32'h1);
    #1;
    want = exp_q.pop_front(); n_checks++;
    if ({31'd0, WE} !== want) begin n_fails++; $display("FAIL reset_we: got %b want %h", WE, want); end
    MemWrite = 0;
    reset_ = 1;
  endtask

  task automatic test_fetch();
    exp_q.push_back(32'h08); exp_q.push_back(32'h05); exp_q.push_back(32'h4);
    fetch(32'h20080005);
    want = exp_q.pop_front(); n_checks++;
    if ({26'd0, OP} !== want) begin n_fails++; $display("FAIL fetch_op: got %h want %h", OP, want); end
    want = exp_q.pop_front(); n_checks++;
    if ({26'd0, Funct} !== want) begin n_fails++; $display("FAIL fetch_funct: got %h want %h", Funct, want); end
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL fetch_pc: got %h want %h", Adr, want); end
  endtask

  task automatic test_addi_sw();
    // decode computes branch target PC + (5<<2)
    ALUSrcB = 2'b11; ALUControl = 3'b010; IorD = 1;
    exp_q.push_back(32'd24);
    tick();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL decode_target: got %h want %h", Adr, want); end
    ALUSrcA = 1; ALUSrcB = 2'b10;
    exp_q.push_back(32'd5);
    tick();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL addi_exec: got %h want %h", Adr, want); end
    idle(); RegWrite = 1;
    exp_q.push_back(32'd0);
    tick();
    idle();
    want = exp_q.pop_front(); n_checks++;
    if (WD !== want) begin n_fails++; $display("FAIL no_bypass: got %h want %h", WD, want); end
    exp_q.push_back(32'h2B); exp_q.push_back(32'd5); exp_q.push_back(32'd8);
    fetch(32'hAC080000);
    want = exp_q.pop_front(); n_checks++;
    if ({26'd0, OP} !== want) begin n_fails++; $display("FAIL sw_op: got %h want %h", OP, want); end
    want = exp_q.pop_front(); n_checks++;
    if (WD !== want) begin n_fails++; $display("FAIL sw_wd: got %h want %h", WD, want); end
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL sw_pc: got %h want %h", Adr, want); end
    MemWrite = 1;
    exp_q.push_back(32'h1);
    #1;
    want = exp_q.pop_front(); n_checks++;
    if ({31'd0, WE} !== want) begin n_fails++; $display("FAIL sw_we: got %b want %h", WE, want); end
    MemWrite = 0;
  endtask

  task automatic test_beq();
    fetch(32'h11080003);
    ALUSrcB = 2'b11; ALUControl = 3'b010; IorD = 1;
    exp_q.push_back(32'd24);
    tick();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL beq_target: got %h want %h", Adr, want); end
    idle(); ALUSrcA = 1; ALUControl = 3'b110; Branch = 1; PCSrc = 2'b01;
    exp_q.push_back(32'd24);
    tick();
    idle();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL beq_taken_pc: got %h want %h", Adr, want); end
    // the fetch edge still reads registers through the previous IR (rt=8)
    exp_q.push_back(32'd5);
    fetch(32'h11000003);
    want = exp_q.pop_front(); n_checks++;
    if (WD !== want) begin n_fails++; $display("FAIL old_ir_read: got %h want %h", WD, want); end
    ALUSrcB = 2'b11; ALUControl = 3'b010;
    exp_q.push_back(32'd0);
    tick();
    want = exp_q.pop_front(); n_checks++;
    if (WD !== want) begin n_fails++; $display("FAIL new_ir_read: got %h want %h", WD, want); end
    idle(); ALUSrcA = 1; ALUControl = 3'b110; Branch = 1; PCSrc = 2'b01;
    exp_q.push_back(32'd28);
    tick();
    idle();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL beq_not_taken_pc: got %h want %h", Adr, want); end
  endtask

  task automatic test_jump_r0();
    fetch(32'h08000010);
    PCSrc = 2'b10; PCWrite = 1;
    exp_q.push_back(32'h40); exp_q.push_back(32'h02);
    tick();
    idle();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL jump_pc: got %h want %h", Adr, want); end
    want = exp_q.pop_front(); n_checks++;
    if ({26'd0, OP} !== want) begin n_fails++; $display("FAIL jump_op: got %h want %h", OP, want); end
    RegWrite = 1; MemtoReg = 1;
    tick();
    idle();
    exp_q.push_back(32'd0);
    tick();
    want = exp_q.pop_front(); n_checks++;
    if (WD !== want) begin n_fails++; $display("FAIL r0_write: got %h want %h", WD, want); end
  endtask

  task automatic test_overflow_alu();
    exp_q.push_back(32'h20);
    fetch(32'h014B5020);
    want = exp_q.pop_front(); n_checks++;
    if ({26'd0, Funct} !== want) begin n_fails++; $display("FAIL rtype_funct: got %h want %h", Funct, want); end
    RD = 32'h7FFFFFFF; tick();
    RD = 32'h00000001; RegWrite = 1; RegDst = 1; MemtoReg = 1; tick();
    RegDst = 0; tick();
    idle(); tick();
    exp_q.push_back(32'd1);
    want = exp_q.pop_front(); n_checks++;
    if (WD !== want) begin n_fails++; $display("FAIL b_eq_one: got %h want %h", WD, want); end
    ALUSrcA = 1; ALUControl = 3'b010; IorD = 1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h80000000);
    #1;
    want = exp_q.pop_front(); n_checks++;
    if ({31'd0, overflow} !== want) begin n_fails++; $display("FAIL add_overflow: got %b want %h", overflow, want); end
    tick();
    want = exp_q.pop_front(); n_checks++;
    if (Adr !== want) begin n_fails++; $display("FAIL add_wrap: got %h want %h", Adr, want); end
    ALUControl = 3'b110;
    exp_q.push_back(32'h0);
    #1;
    want = exp_q.pop_front(); n_checks++;
    if ({31'd0, overflow} !== want) begin n_fails++; $display("FAIL sub_no_overflow: got %b want %h", overflow, want); end
    idle();
    RD = 32'hFFFFFFFF; tick();
    RegWrite = 1; RegDst = 1; MemtoReg = 1; tick();
    idle(); tick();
    ALUSrcA = 1; IorD = 1;
    for (int i = 0; i < 8; i++) begin
      ALUControl = ALU_CTL[i];
      exp_q.push_back(ALU_RES[i]);
      tick();
      want = exp_q.pop_front(); n_checks++;
      if (Adr !== want) begin
        n_fails++;
        $display("FAIL alu_ctl_%b: got %h want %h", ALU_CTL[i], Adr, want);
      end
    end
    idle();
  endtask

  initial begin
    reset_ = 0; RD = 32'h0;
    idle();
    test_reset();
    test_fetch();
    test_addi_sw();
    test_beq();
    test_jump_r0();
    test_overflow_alu();
    if (exp_q.size() != 0) begin
      n_checks++; n_fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
